// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and decode helpers for the EXE-stage multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  // Divide family occupies the upper half of the funct3 space.
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // rs1 is treated as two's complement for MULH, MULHSU, DIV and REM.
  function automatic logic is_signed_rs1(input logic [2:0] op);
    logic res;
    case (op)
      OP_MULH, OP_MULHSU, OP_DIV, OP_REM: res = 1'b1;
      default:                            res = 1'b0;
    endcase
    return res;
  endfunction

  // rs2 is treated as two's complement for MULH, DIV and REM only.
  function automatic logic is_signed_rs2(input logic [2:0] op);
    logic res;
    case (op)
      OP_MULH, OP_DIV, OP_REM: res = 1'b1;
      default:                 res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// mdu_div_iter: restoring-division step on operand magnitudes. The dividend
// register shifts left as quotient bits enter at the bottom; the partial
// remainder lives beside it. Next-state values are exported so the parent can
// capture the final quotient/remainder on the same edge as the last step.
module mdu_div_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quo_next,
  output logic [DATA_WIDTH-1:0] rem_next
);

  localparam int W = DATA_WIDTH;

  logic [W-1:0] quo_r;
  logic [W-1:0] rem_r;
  logic [W-1:0] dvs_r;
  logic [W:0]   part_s;
  logic [W-1:0] diff_s;

  // One trial subtraction: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    part_s = {rem_r, quo_r[W-1]};
    diff_s = part_s[W-1:0] - dvs_r;
    if (part_s >= {1'b0, dvs_r}) begin
      rem_next = diff_s;
      quo_next = {quo_r[W-2:0], 1'b1};
    end else begin
      rem_next = part_s[W-1:0];
      quo_next = {quo_r[W-2:0], 1'b0};
    end
  end

  // Operand load on accept, then one quotient bit per step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_r <= {W{1'b0}};
      rem_r <= {W{1'b0}};
      dvs_r <= {W{1'b0}};
    end else if (load) begin
      quo_r <= dividend;
      rem_r <= {W{1'b0}};
      dvs_r <= divisor;
    end else if (step) begin
      quo_r <= quo_next;
      rem_r <= rem_next;
    end
  end

endmodule

// File: rtl/exe_mdu.sv
// exe_mdu: multi-cycle RV32M multiply/divide unit with valid/ready handshake.
// Build option MDU_DIV_EN: when defined, the restoring divider and the
// divide-by-zero / signed-overflow fast paths are present; when undefined,
// divide ops complete in one cycle with a zero result.
module exe_mdu
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] rs1_i,
  input  logic [DATA_WIDTH-1:0] rs2_i,
  input  logic [TAG_W-1:0]      rd_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [TAG_W-1:0]      rd_o,
  output logic                  busy_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  mdu_state_e      state_r, state_nx;
  logic [2:0]      op_r;
  logic [TAG_W-1:0] rd_r;
  logic            neg_r;
  logic [CW-1:0]   cnt_r;
  logic [W-1:0]    mcand_r;
  logic [2*W-1:0]  acc_r;
  logic [W-1:0]    result_r;
  logic            valid_r, busy_r;

  logic            accept_s, step_s, last_s, s1_s, s2_s;
  logic [W-1:0]    abs1_s, abs2_s;
  logic [W:0]      add_s;
  logic [2*W-1:0]  acc_nx_s, prod_s;
  logic [W-1:0]    mul_res_s, calc_res_s, fast_res_s;
  logic            fast_s;

  assign ready_o  = (state_r == IDLE) && !flush;
  assign accept_s = valid_i && ready_o;
  assign step_s   = (state_r == CALC) && !flush;
  assign last_s   = (cnt_r == CW'(1));
  assign valid_o  = valid_r;
  assign busy_o   = busy_r;
  assign result_o = result_r;
  assign rd_o     = rd_r;

  // Operand sign extraction and magnitudes for the iterative datapaths.
  always_comb begin
    s1_s = is_signed_rs1(op_i) & rs1_i[W-1];
    s2_s = is_signed_rs2(op_i) & rs2_i[W-1];
    if (s1_s) abs1_s = -rs1_i; else abs1_s = rs1_i;
    if (s2_s) abs2_s = -rs2_i; else abs2_s = rs2_i;
  end

  // Shift-add step: add multiplicand to the top half when the LSB is set, then shift right.
  always_comb begin
    add_s    = {1'b0, acc_r[2*W-1:W]} + {1'b0, (acc_r[0] ? mcand_r : {W{1'b0}})};
    acc_nx_s = {add_s, acc_r[W-1:1]};
    if (neg_r) prod_s = -acc_nx_s; else prod_s = acc_nx_s;
    if (op_r == OP_MUL) mul_res_s = prod_s[W-1:0]; else mul_res_s = prod_s[2*W-1:W];
  end

`ifdef MDU_DIV_EN
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  logic         s1_r;
  logic         div_zero_s, ovf_s;
  logic [W-1:0] quo_nx_s, rem_nx_s, quo_s, rem_s;

  mdu_div_iter #(.DATA_WIDTH(W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (accept_s),
    .step     (step_s),
    .dividend (abs1_s),
    .divisor  (abs2_s),
    .quo_next (quo_nx_s),
    .rem_next (rem_nx_s)
  );

  // Divide-by-zero and signed overflow results are known without iterating.
  always_comb begin
    div_zero_s = (rs2_i == {W{1'b0}});
    ovf_s      = is_signed_rs1(op_i) && (rs1_i == MOST_NEG) && (rs2_i == {W{1'b1}});
    fast_s     = is_div(op_i) && (div_zero_s || ovf_s);
    if (div_zero_s) fast_res_s = op_i[1] ? rs1_i : {W{1'b1}};
    else            fast_res_s = op_i[1] ? {W{1'b0}} : rs1_i;
  end

  // Final signed fix-up: quotient takes sign(rs1)^sign(rs2), remainder takes sign(rs1).
  always_comb begin
    if (neg_r) quo_s = -quo_nx_s; else quo_s = quo_nx_s;
    if (s1_r)  rem_s = -rem_nx_s; else rem_s = rem_nx_s;
    if (is_div(op_r)) calc_res_s = op_r[1] ? rem_s : quo_s;
    else              calc_res_s = mul_res_s;
  end

  // Dividend sign kept for the remainder fix-up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           s1_r <= 1'b0;
    else if (accept_s) s1_r <= s1_s;
  end
`else
  assign fast_s     = is_div(op_i);
  assign fast_res_s = {W{1'b0}};
  assign calc_res_s = mul_res_s;
`endif

  // Next-state: flush wins over everything, including the result handshake.
  always_comb begin
    state_nx = state_r;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state_r)
        IDLE:    if (valid_i) state_nx = fast_s ? DONE : CALC; else state_nx = IDLE;
        CALC:    if (last_s)  state_nx = DONE; else state_nx = CALC;
        DONE:    if (ready_i) state_nx = IDLE; else state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // State register with registered valid/busy decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      valid_r <= (state_nx == DONE);
      busy_r  <= (state_nx != IDLE);
    end
  end

  // Request capture, multiplier iteration and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r     <= 3'd0;
      rd_r     <= {TAG_W{1'b0}};
      neg_r    <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      mcand_r  <= {W{1'b0}};
      acc_r    <= {(2*W){1'b0}};
      result_r <= {W{1'b0}};
    end else if (accept_s) begin
      op_r    <= op_i;
      rd_r    <= rd_i;
      neg_r   <= s1_s ^ s2_s;
      cnt_r   <= CW'(W);
      mcand_r <= abs1_s;
      acc_r   <= {{W{1'b0}}, abs2_s};
      if (fast_s) result_r <= fast_res_s;
    end else if (step_s) begin
      acc_r <= acc_nx_s;
      cnt_r <= cnt_r - CW'(1);
      if (last_s) result_r <= calc_res_s;
    end
  end

endmodule

// File: tb/tb_exe_mdu.sv
// tb_exe_mdu: scoreboard bench for exe_mdu at DATA_WIDTH=32.
module tb_exe_mdu;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst, flush, valid_i, ready_i;
  logic        ready_o, valid_o, busy_o;
  logic [2:0]  op_i;
  logic [31:0] rs1_i, rs2_i, result_o;
  logic [4:0]  rd_i, rd_o;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  exe_mdu #(.DATA_WIDTH(W), .TAG_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .rd_i     (rd_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .rd_o     (rd_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected divide-family result in this build.
  function automatic logic [31:0] dexp(input logic [31:0] x);
`ifdef MDU_DIV_EN
    return x;
`else
    return 32'd0 & x;
`endif
  endfunction

  function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_DIV_EN
    return op[2] && ((b == 32'd0) ||
                     ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`else
    return op[2] && (a == a) && (b == b);
`endif
  endfunction

  // Independent RV32M reference using wide native arithmetic.
  function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] x, y, p;
    logic signed [31:0] sa, sb;
`ifndef MDU_DIV_EN
    if (op[2]) return 32'd0;
`endif
    x  = {{32{a[31]}}, a};
    y  = {{32{b[31]}}, b};
    sa = a;
    sb = b;
    case (op)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = x * y; return p[63:32]; end
      3'd2: begin y = {32'd0, b}; p = x * y; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return sa / sb;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Issue one request, wait for the result, compare against the scoreboard, then retire it.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int hold);
    exp_t e;
    exp_t g;
    int   lat;
    bit   seen;
    @(negedge clk);
    check_value("ready_idle", 32'(ready_o), 32'd1);
    valid_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_i = rd;
    e.res = exp; e.rd = rd; e.lat = is_fast(op, a, b) ? 0 : W;
    sb_q.push_back(e);
    @(posedge clk);
    #1 valid_i = 1'b0;
    @(negedge clk);
    lat  = 0;
    seen = valid_o;
    while (!seen && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      seen = valid_o;
    end
    g = sb_q.pop_front();
    if (!seen) begin
      check_value("timeout", 32'd0, 32'd1);
    end else begin
      check_value("latency", 32'(lat), 32'(g.lat));
      check_value("result", result_o, g.res);
      check_value("rd", 32'(rd_o), 32'(g.rd));
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        @(negedge clk);
        check_value("hold_valid", 32'(valid_o), 32'd1);
        check_value("hold_result", result_o, g.res);
        check_value("hold_ready", 32'(ready_o), 32'd0);
      end
      ready_i = 1'b1;
      @(posedge clk);
      #1 ready_i = 1'b0;
      @(negedge clk);
      check_value("retire", 32'({valid_o, busy_o}), 32'd0);
    end
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    bit          seen_v;

    rst = 1'b1; flush = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    op_i = 3'd0; rs1_i = 32'd0; rs2_i = 32'd0; rd_i = 5'd0;
    repeat (3) @(negedge clk);
    check_value("rst_valid", 32'(valid_o), 32'd0);
    check_value("rst_busy", 32'(busy_o), 32'd0);
    check_value("rst_result", result_o, 32'd0);
    check_value("rst_rd", 32'(rd_o), 32'd0);
    check_value("rst_ready", 32'(ready_o), 32'd1);
    rst = 1'b0;

    // Directed vectors
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0000, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, dexp(32'hFFFF_FFFD), 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, dexp(32'hFFFF_FFFF), 0);
    run_op(3'd5, 32'd100, 32'd7, 5'd11, dexp(32'd14), 0);
    run_op(3'd7, 32'd100, 32'd7, 5'd12, dexp(32'd2), 0);
    run_op(3'd4, 32'd5, 32'd0, 5'd13, dexp(32'hFFFF_FFFF), 0);
    run_op(3'd6, 32'd5, 32'd0, 5'd14, dexp(32'd5), 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, dexp(32'h8000_0000), 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, 0);

    // Random vectors against the reference model
    for (int k = 0; k < 20; k++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      run_op(op, a, b, 5'(k + 1), ref_mdu(op, a, b), 0);
    end

    // Backpressure: result held while ready_i is low
    run_op(3'd0, 32'h1234, 32'h10, 5'd20, 32'h0001_2340, 5);

    // Flush in the middle of a multiply
    @(negedge clk);
    valid_i = 1'b1; op_i = 3'd0; rs1_i = 32'd5; rs2_i = 32'd6; rd_i = 5'd3;
    @(posedge clk);
    #1 valid_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    check_value("flush_ready", 32'(ready_o), 32'd0);
    check_value("flush_busy_before", 32'(busy_o), 32'd1);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check_value("flush_idle", 32'({valid_o, busy_o, ready_o}), 32'd1);
    seen_v = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      seen_v = seen_v | valid_o;
    end
    check_value("flush_no_valid", 32'(seen_v), 32'd0);

    // Flush together with a request: not accepted
    @(negedge clk);
    valid_i = 1'b1; flush = 1'b1; op_i = 3'd0; rs1_i = 32'd2; rs2_i = 32'd2; rd_i = 5'd4;
    #1;
    check_value("flush_req_ready", 32'(ready_o), 32'd0);
    @(posedge clk);
    #1 begin valid_i = 1'b0; flush = 1'b0; end
    @(negedge clk);
    check_value("flush_req_busy", 32'(busy_o), 32'd0);

    // Reset during CALC
    @(negedge clk);
    valid_i = 1'b1; op_i = 3'd0; rs1_i = 32'd9; rs2_i = 32'd9; rd_i = 5'd9;
    @(posedge clk);
    #1 valid_i = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_value("pre_rst_busy", 32'(busy_o), 32'd1);
    rst = 1'b1;
    #1;
    check_value("mid_rst_busy", 32'(busy_o), 32'd0);
    check_value("mid_rst_valid", 32'(valid_o), 32'd0);
    check_value("mid_rst_result", result_o, 32'd0);
    check_value("mid_rst_rd", 32'(rd_o), 32'd0);
    check_value("mid_rst_ready", 32'(ready_o), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run_op(3'd0, 32'd3, 32'd4, 5'd12, 32'd12, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
